// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: data-memory load/store with ready handshake, stall and fault flags
// Drives the data-memory port from the EX/MEM register and registers the write-back result.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memtoreg_in,
  input  logic        regwrite_in,
  input  logic [3:0]  memwrite_in,
  input  logic [31:0] ALUout_in,
  input  logic [31:0] rdata2_in,
  input  logic [31:0] immgen_in,
  input  logic [1:0]  regin_in,
  input  logic [31:0] PC_plus4_in,
  input  logic [31:0] inst_data_in,
  input  logic        invalid_in,
  output logic        dmem_req,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out,
  output logic        wb_valid,
  output logic        wb_regwrite,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [31:0] wb_inst,
  output logic [31:0] wb_pc_plus4,
  output logic        misalign_fault,
  output logic        bus_fault
);

  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [1:0]  addr_lo;
  logic        access, bad_size, aligned, misalign, timeout_hit, fault;
  logic [31:0] lane_word, load_val, wb_mux;

  assign funct3  = inst_data_in[14:12];
  assign rd      = inst_data_in[11:7];
  assign addr_lo = ALUout_in[1:0];

  // Reset gates the request so the bus drops asynchronously with reset.
  assign access   = !reset && !invalid_in && (memtoreg_in || (|memwrite_in));
  assign bad_size = (funct3[1:0] == 2'b11) || (memtoreg_in && funct3 == 3'b110);
  assign aligned  = !bad_size &&
                    ((funct3[1:0] == 2'b00) ||
                     (funct3[1:0] == 2'b01 && !addr_lo[0]) ||
                     (funct3[1:0] == 2'b10 && addr_lo == 2'b00));
  assign misalign    = access && !aligned;
  assign timeout_hit = (state == S_WAIT) && !dmem_ready && (wait_cnt == TMO);
  assign fault       = misalign || timeout_hit;

  assign dmem_req   = !reset && ((state == S_WAIT) || (access && aligned));
  assign stall_out  = dmem_req && !dmem_ready && !timeout_hit;
  assign dmem_we    = dmem_req ? memwrite_in : 4'b0000;
  assign dmem_addr  = {ALUout_in[31:2], 2'b00};

  always_comb begin
    dmem_wdata = rdata2_in;
    case (funct3[1:0])
      2'b00:   dmem_wdata = {4{rdata2_in[7:0]}};
      2'b01:   dmem_wdata = {2{rdata2_in[15:0]}};
      default: dmem_wdata = rdata2_in;
    endcase
  end

  assign lane_word = dmem_rdata >> {addr_lo, 3'b000};

  always_comb begin
    load_val = dmem_rdata;
    case (funct3)
      3'b000:  load_val = {{24{lane_word[7]}}, lane_word[7:0]};
      3'b001:  load_val = {{16{lane_word[15]}}, lane_word[15:0]};
      3'b100:  load_val = {24'h0, lane_word[7:0]};
      3'b101:  load_val = {16'h0, lane_word[15:0]};
      default: load_val = dmem_rdata;
    endcase
  end

  always_comb begin
    wb_mux = ALUout_in;
    case (regin_in)
      2'b00:   wb_mux = ALUout_in;
      2'b01:   wb_mux = load_val;
      2'b10:   wb_mux = PC_plus4_in;
      default: wb_mux = immgen_in;
    endcase
  end

  // WAIT cycle k sees wait_cnt == k, so the fault lands on WAIT cycle TIMEOUT_CYCLES.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dmem_req && !dmem_ready) begin
            state    <= S_WAIT;
            wait_cnt <= CW'(1);
          end
        end
        default: begin
          if (dmem_ready || timeout_hit) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid       <= 1'b0;
      wb_regwrite    <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
      wb_inst        <= '0;
      wb_pc_plus4    <= '0;
      misalign_fault <= 1'b0;
      bus_fault      <= 1'b0;
    end else if (stall_out) begin
      wb_valid       <= 1'b0;
      wb_regwrite    <= 1'b0;
      misalign_fault <= 1'b0;
      bus_fault      <= 1'b0;
    end else begin
      wb_valid       <= !invalid_in;
      wb_regwrite    <= regwrite_in && !invalid_in && !fault && (rd != 5'd0);
      wb_rd          <= rd;
      wb_data        <= wb_mux;
      wb_inst        <= inst_data_in;
      wb_pc_plus4    <= PC_plus4_in;
      misalign_fault <= misalign;
      bus_fault      <= timeout_hit;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
// Instance runs with TIMEOUT_CYCLES=4 so the bus timeout is reachable quickly.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        memtoreg_in, regwrite_in, invalid_in;
  logic [3:0]  memwrite_in;
  logic [31:0] ALUout_in, rdata2_in, immgen_in, PC_plus4_in, inst_data_in;
  logic [1:0]  regin_in;
  logic        dmem_req, dmem_ready, stall_out;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_valid, wb_regwrite, misalign_fault, bus_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, wb_inst, wb_pc_plus4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in), .memwrite_in(memwrite_in),
    .ALUout_in(ALUout_in), .rdata2_in(rdata2_in), .immgen_in(immgen_in),
    .regin_in(regin_in), .PC_plus4_in(PC_plus4_in), .inst_data_in(inst_data_in),
    .invalid_in(invalid_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall_out(stall_out),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_inst(wb_inst), .wb_pc_plus4(wb_pc_plus4),
    .misalign_fault(misalign_fault), .bus_fault(bus_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic mtr, input logic rw, input logic [3:0] mw,
                       input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] imm,
                       input logic [1:0] sel, input logic [2:0] f3, input logic [4:0] rd,
                       input logic inv);
    memtoreg_in  = mtr;
    regwrite_in  = rw;
    memwrite_in  = mw;
    ALUout_in    = addr;
    rdata2_in    = rs2;
    immgen_in    = imm;
    regin_in     = sel;
    PC_plus4_in  = 32'h0000_1004;
    inst_data_in = {17'h0, f3, rd, 7'h03};
    invalid_in   = inv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    drive(0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 2'd0, 3'd0, 5'd0, 1);
    #3;
    chk("rst_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_stall", {31'h0, stall_out}, 32'h0);
    chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    step();
    step();
    reset = 1'b0;

    // LW 0x100, zero-wait
    drive(1, 1, 4'h0, 32'h100, 32'h0, 32'h0, 2'd1, 3'b010, 5'd5, 0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_req", {31'h0, dmem_req}, 32'h1);
    chk("lw_stall", {31'h0, stall_out}, 32'h0);
    chk("lw_addr", dmem_addr, 32'h100);
    chk("lw_we", {28'h0, dmem_we}, 32'h0);
    step();
    chk("lw_data", wb_data, 32'hDEADBEEF);
    chk("lw_regwrite", {31'h0, wb_regwrite}, 32'h1);
    chk("lw_rd", {27'h0, wb_rd}, 32'd5);
    chk("lw_valid", {31'h0, wb_valid}, 32'h1);

    // LB / LBU / LH lane extraction
    dmem_rdata = 32'h80123456;
    drive(1, 1, 4'h0, 32'h103, 32'h0, 32'h0, 2'd1, 3'b000, 5'd6, 0);
    step();
    chk("lb_data", wb_data, 32'hFFFFFF80);
    drive(1, 1, 4'h0, 32'h103, 32'h0, 32'h0, 2'd1, 3'b100, 5'd6, 0);
    step();
    chk("lbu_data", wb_data, 32'h00000080);
    dmem_rdata = 32'h8001_7F00;
    drive(1, 1, 4'h0, 32'h102, 32'h0, 32'h0, 2'd1, 3'b001, 5'd6, 0);
    step();
    chk("lh_data", wb_data, 32'hFFFF8001);
    drive(1, 1, 4'h0, 32'h101, 32'h0, 32'h0, 2'd1, 3'b100, 5'd6, 0);
    step();
    chk("lbu1_data", wb_data, 32'h0000007F);

    // SH with three wait cycles
    dmem_ready = 1'b0;
    drive(0, 0, 4'b1100, 32'h202, 32'h1234ABCD, 32'h0, 2'd0, 3'b001, 5'd0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sh_stall", {31'h0, stall_out}, 32'h1);
      chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
      chk("sh_we", {28'h0, dmem_we}, 32'hC);
      chk("sh_addr", dmem_addr, 32'h200);
      step();
      chk("sh_bubble", {31'h0, wb_valid}, 32'h0);
    end
    dmem_ready = 1'b1;
    #1;
    chk("sh_done_stall", {31'h0, stall_out}, 32'h0);
    step();
    chk("sh_wb_valid", {31'h0, wb_valid}, 32'h1);
    chk("sh_wb_regwrite", {31'h0, wb_regwrite}, 32'h0);

    // Misaligned LW
    drive(1, 1, 4'h0, 32'h102, 32'h0, 32'h0, 2'd1, 3'b010, 5'd8, 0);
    #1;
    chk("mis_req", {31'h0, dmem_req}, 32'h0);
    chk("mis_stall", {31'h0, stall_out}, 32'h0);
    step();
    chk("mis_fault", {31'h0, misalign_fault}, 32'h1);
    chk("mis_valid", {31'h0, wb_valid}, 32'h1);
    chk("mis_regwrite", {31'h0, wb_regwrite}, 32'h0);

    // Bus timeout
    dmem_ready = 1'b0;
    drive(1, 1, 4'h0, 32'h300, 32'h0, 32'h0, 2'd1, 3'b010, 5'd7, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("tmo_stall", {31'h0, stall_out}, 32'h1);
      step();
    end
    #1;
    chk("tmo_last_stall", {31'h0, stall_out}, 32'h0);
    step();
    chk("tmo_bus_fault", {31'h0, bus_fault}, 32'h1);
    chk("tmo_valid", {31'h0, wb_valid}, 32'h1);
    chk("tmo_regwrite", {31'h0, wb_regwrite}, 32'h0);

    // Back in IDLE: ALU op completes in one clock, fault cleared
    drive(0, 1, 4'h0, 32'h55, 32'h0, 32'h0, 2'd0, 3'b000, 5'd3, 0);
    #1;
    chk("alu_req", {31'h0, dmem_req}, 32'h0);
    step();
    chk("alu_data", wb_data, 32'h55);
    chk("alu_bus_fault", {31'h0, bus_fault}, 32'h0);
    chk("alu_regwrite", {31'h0, wb_regwrite}, 32'h1);

    // Invalid store never requests
    drive(0, 1, 4'hF, 32'h400, 32'h0, 32'h0, 2'd0, 3'b010, 5'd3, 1);
    #1;
    chk("inv_req", {31'h0, dmem_req}, 32'h0);
    step();
    chk("inv_valid", {31'h0, wb_valid}, 32'h0);

    // rd=0 suppresses regwrite; PC+4 and immediate selects
    drive(0, 1, 4'h0, 32'h0, 32'h0, 32'h0, 2'd2, 3'b000, 5'd0, 0);
    step();
    chk("rd0_regwrite", {31'h0, wb_regwrite}, 32'h0);
    chk("pc4_data", wb_data, 32'h00001004);
    drive(0, 1, 4'h0, 32'h0, 32'h0, 32'hCAFE0000, 2'd3, 3'b000, 5'd9, 0);
    step();
    chk("imm_data", wb_data, 32'hCAFE0000);

    // Reset asserted mid-WAIT
    drive(1, 1, 4'h0, 32'h500, 32'h0, 32'h0, 2'd1, 3'b010, 5'd4, 0);
    step();
    chk("rw_stall_wait", {31'h0, stall_out}, 32'h1);
    reset = 1'b1;
    #1;
    chk("rw_req", {31'h0, dmem_req}, 32'h0);
    chk("rw_stall", {31'h0, stall_out}, 32'h0);
    chk("rw_wb_data", wb_data, 32'h0);
    chk("rw_wb_inst", wb_inst, 32'h0);
    chk("rw_bus_fault", {31'h0, bus_fault}, 32'h0);
    drive(0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 2'd0, 3'b000, 5'd0, 1);
    step();
    reset = 1'b0;
    #1;
    chk("rw_idle_req", {31'h0, dmem_req}, 32'h0);
    step();
    chk("rw_idle_fault", {31'h0, bus_fault}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
